// File: rtl/zynq_axil_mailbox_pkg.sv
// Shared offsets, response codes and helpers for the AXI-Lite mailbox.
// Offsets are word indices taken from addr[4:2].
package zynq_axil_mailbox_pkg;

    localparam logic [2:0] OFF_H2P      = 3'd0;
    localparam logic [2:0] OFF_P2H      = 3'd1;
    localparam logic [2:0] OFF_H2P_FREE = 3'd2;
    localparam logic [2:0] OFF_P2H_CNT  = 3'd3;
    localparam logic [2:0] OFF_SCRATCH  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zynq_mailbox_fifo.sv
// Single-clock ring FIFO with wrap-around pointers and an occupancy count.
// Push when full and pop when empty are ignored.
module zynq_mailbox_fifo #(
    parameter int els_p   = 8,
    parameter int width_p = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         pop_i,
    output logic [width_p-1:0]           data_o,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(els_p);
    localparam int CW = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CW'(els_p));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/zynq_axil_mailbox.sv
// AXI4-Lite mailbox: h2p and p2h word FIFOs, status counts and scratch.
// Handshakes, decode and response registers live here.
module zynq_axil_mailbox
    import zynq_axil_mailbox_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int fifo_els_p         = 8
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [31:0]                     h2p_data_o,
    output logic                            h2p_v_o,
    input  logic                            h2p_ready_i,
    input  logic [31:0]                     p2h_data_i,
    input  logic                            p2h_v_i,
    output logic                            p2h_ready_o
);

    localparam int CW = $clog2(fifo_els_p + 1);

    logic          alive_q;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d, scratch_q, scratch_d;
    logic          wr_go, rd_go, h2p_push, p2h_pop;
    logic          h2p_full, h2p_empty, p2h_full, p2h_empty;
    logic [CW-1:0] h2p_cnt, p2h_cnt, h2p_free;
    logic [31:0]   p2h_head;
    logic [2:0]    woff, roff;
    logic          unused_ok;

    // alive_q keeps every ready low until the first edge after reset release
    assign wr_go = alive_q & s_axi_awvalid & s_axi_wvalid
                 & (~bvalid_q | s_axi_bready);
    assign rd_go = s_axi_arvalid & s_axi_arready;

    assign s_axi_awready = wr_go;
    assign s_axi_wready  = wr_go;
    assign s_axi_arready = alive_q & (~rvalid_q | s_axi_rready);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign h2p_v_o     = ~h2p_empty;
    assign p2h_ready_o = alive_q & ~p2h_full;
    assign h2p_free    = CW'(fifo_els_p) - h2p_cnt;
    assign woff        = s_axi_awaddr[4:2];
    assign roff        = s_axi_araddr[4:2];
    assign unused_ok   = &{1'b0, s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:5],
                           s_axi_awaddr[1:0],
                           s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:5],
                           s_axi_araddr[1:0], h2p_full};

    always_comb begin
        bvalid_d  = bvalid_q & ~s_axi_bready;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q & ~s_axi_rready;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        scratch_d = scratch_q;
        h2p_push  = 1'b0;
        p2h_pop   = 1'b0;
        if (wr_go) begin
            bvalid_d = 1'b1;
            unique case (woff)
                OFF_H2P: begin
                    if (s_axi_wstrb == 4'hF && !h2p_full) begin
                        h2p_push = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else begin
                        bresp_d  = RESP_SLVERR;
                    end
                end
                OFF_P2H, OFF_H2P_FREE, OFF_P2H_CNT: bresp_d = RESP_SLVERR;
                OFF_SCRATCH: begin
                    scratch_d = byte_merge(scratch_q, s_axi_wdata, s_axi_wstrb);
                    bresp_d   = RESP_OKAY;
                end
                default: bresp_d = RESP_DECERR;
            endcase
        end
        if (rd_go) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            unique case (roff)
                OFF_H2P: rresp_d = RESP_SLVERR;
                OFF_P2H: begin
                    if (!p2h_empty) begin
                        p2h_pop = 1'b1;
                        rdata_d = p2h_head;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rresp_d = RESP_SLVERR;
                    end
                end
                OFF_H2P_FREE: begin
                    rdata_d = 32'(h2p_free);
                    rresp_d = RESP_OKAY;
                end
                OFF_P2H_CNT: begin
                    rdata_d = 32'(p2h_cnt);
                    rresp_d = RESP_OKAY;
                end
                OFF_SCRATCH: begin
                    rdata_d = scratch_q;
                    rresp_d = RESP_OKAY;
                end
                default: rresp_d = RESP_DECERR;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            alive_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            scratch_q <= '0;
        end else begin
            alive_q   <= 1'b1;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
        end
    end

    zynq_mailbox_fifo #(.els_p(fifo_els_p), .width_p(32)) u_h2p (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (h2p_push),
        .data_i  (s_axi_wdata),
        .pop_i   (h2p_v_o & h2p_ready_i),
        .data_o  (h2p_data_o),
        .count_o (h2p_cnt),
        .full_o  (h2p_full),
        .empty_o (h2p_empty)
    );

    zynq_mailbox_fifo #(.els_p(fifo_els_p), .width_p(32)) u_p2h (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (p2h_v_i & p2h_ready_o),
        .data_i  (p2h_data_i),
        .pop_i   (p2h_pop),
        .data_o  (p2h_head),
        .count_o (p2h_cnt),
        .full_o  (p2h_full),
        .empty_o (p2h_empty)
    );

endmodule
